// File: rtl/prbs_pattern_engine.sv
// prbs_pattern_engine
//   PRBS stream generator that emits HEAD_WORDS PRBS beats, then pattern_in
//   n_repeats times back-to-back, then TAIL_WORDS PRBS beats.
//   It also watches its own accepted beats and counts consecutive aligned
//   occurrences of pattern_in.
//   The window logic assumes PAT_W >= 2*DATA_W.
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           run request, honoured only while idle
//   mode            0=PRBS7, 1=PRBS15, 2=PRBS23, 3=PRBS31
//   seed            LFSR seed, low L bits used; all-zero loads all-ones
//   pattern_in      injected/detected pattern, MSB beat first
//   n_repeats       injected copies and required consecutive matches
//   out_ready       sink ready
//   prbs_out        stream beat, first-in-time bit in MSB
//   prbs_valid      prbs_out valid
//   busy            run in progress
//   match_count     consecutive aligned matches, saturating
//   pattern_found   sticky, set once match_count reaches n_repeats (!=0)
module prbs_pattern_engine #(
    parameter int DATA_W     = 8,
    parameter int PAT_W      = 32,
    parameter int CNT_W      = 8,
    parameter int HEAD_WORDS = 4,
    parameter int TAIL_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [30:0]       seed,
    input  logic [PAT_W-1:0]  pattern_in,
    input  logic [CNT_W-1:0]  n_repeats,
    input  logic              out_ready,
    output logic [DATA_W-1:0] prbs_out,
    output logic              prbs_valid,
    output logic              busy,
    output logic [CNT_W-1:0]  match_count,
    output logic              pattern_found
);

    localparam int PAT_BEATS = PAT_W / DATA_W;
    localparam int SLW       = (PAT_BEATS > 1) ? $clog2(PAT_BEATS) : 1;
    localparam int FLW       = $clog2(PAT_BEATS + 1);
    localparam int PCW       = CNT_W + SLW + 1;
    localparam int HTMAX     = (HEAD_WORDS > TAIL_WORDS) ? HEAD_WORDS : TAIL_WORDS;
    localparam int HTW       = $clog2(HTMAX + 1);
    localparam int HW        = PAT_W - DATA_W;

    typedef enum logic [1:0] {S_IDLE, S_HEAD, S_PAT, S_TAIL} state_t;

    state_t           state;
    logic [1:0]       mode_reg;
    logic [PAT_W-1:0] pat_reg;
    logic [PAT_W-1:0] pat_rot;
    logic [CNT_W-1:0] n_reg;
    logic [30:0]      lfsr;
    logic [HTW-1:0]   ht_cnt;
    logic [PCW-1:0]   pat_cnt;

    logic              xfer;
    logic              start_acc;
    logic [30:0]       seed_mask;
    logic [30:0]       seed_load;
    logic [30:0]       gen_src;
    logic [1:0]        gen_mode;
    logic [30:0]       gen_s;
    logic              gen_fb;
    logic [DATA_W-1:0] gen_beat;
    logic [30:0]       gen_state;
    logic [DATA_W-1:0] pat_top;
    logic [PAT_W-1:0]  pat_rot_next;
    logic [PCW-1:0]    pat_total;

    function automatic logic lfsr_fb(input logic [30:0] s, input logic [1:0] m);
        case (m)
            2'd0:    return s[6]  ^ s[5];
            2'd1:    return s[14] ^ s[13];
            2'd2:    return s[22] ^ s[17];
            default: return s[30] ^ s[27];
        endcase
    endfunction

    assign xfer      = prbs_valid & out_ready;
    assign start_acc = (state == S_IDLE) & start;

    always_comb begin
        case (mode)
            2'd0:    seed_mask = 31'h0000_007F;
            2'd1:    seed_mask = 31'h0000_7FFF;
            2'd2:    seed_mask = 31'h007F_FFFF;
            default: seed_mask = 31'h7FFF_FFFF;
        endcase
        seed_load = ((seed & seed_mask) == '0) ? '1 : (seed & seed_mask);
    end

    // One beat of DATA_W serial steps. While idle the generator runs from the
    // seed so the first HEAD beat is registered on the accepted-start edge.
    always_comb begin
        gen_src  = (state == S_IDLE) ? seed_load : lfsr;
        gen_mode = (state == S_IDLE) ? mode : mode_reg;
        gen_beat = '0;
        gen_fb   = 1'b0;
        gen_s    = gen_src;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            gen_fb                = lfsr_fb(gen_s, gen_mode);
            gen_beat[DATA_W-1-i]  = gen_fb;
            gen_s                 = {gen_s[29:0], gen_fb};
        end
        gen_state = gen_s;
    end

    // The pattern is emitted from a rotating copy, so beat k naturally picks
    // slice k mod PAT_BEATS across repeats.
    assign pat_top      = pat_rot[PAT_W-1 -: DATA_W];
    assign pat_rot_next = {pat_rot[PAT_W-DATA_W-1:0], pat_rot[PAT_W-1 -: DATA_W]};
    assign pat_total    = PCW'(n_reg) * PCW'(PAT_BEATS);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            prbs_out   <= '0;
            prbs_valid <= 1'b0;
            busy       <= 1'b0;
            lfsr       <= '1;
            mode_reg   <= '0;
            pat_reg    <= '0;
            pat_rot    <= '0;
            n_reg      <= '0;
            ht_cnt     <= '0;
            pat_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    mode_reg   <= mode;
                    pat_reg    <= pattern_in;
                    pat_rot    <= pattern_in;
                    n_reg      <= n_repeats;
                    prbs_out   <= gen_beat;
                    lfsr       <= gen_state;
                    prbs_valid <= 1'b1;
                    busy       <= 1'b1;
                    ht_cnt     <= HTW'(1);
                    state      <= S_HEAD;
                end
                S_HEAD: if (xfer) begin
                    if (ht_cnt == HTW'(HEAD_WORDS)) begin
                        if (n_reg != '0) begin
                            prbs_out <= pat_top;
                            pat_rot  <= pat_rot_next;
                            pat_cnt  <= PCW'(1);
                            state    <= S_PAT;
                        end else begin
                            prbs_out <= gen_beat;
                            lfsr     <= gen_state;
                            ht_cnt   <= HTW'(1);
                            state    <= S_TAIL;
                        end
                    end else begin
                        prbs_out <= gen_beat;
                        lfsr     <= gen_state;
                        ht_cnt   <= ht_cnt + 1'b1;
                    end
                end
                // LFSR is left untouched here so TAIL resumes the HEAD sequence.
                S_PAT: if (xfer) begin
                    if (pat_cnt == pat_total) begin
                        prbs_out <= gen_beat;
                        lfsr     <= gen_state;
                        ht_cnt   <= HTW'(1);
                        state    <= S_TAIL;
                    end else begin
                        prbs_out <= pat_top;
                        pat_rot  <= pat_rot_next;
                        pat_cnt  <= pat_cnt + 1'b1;
                    end
                end
                S_TAIL: if (xfer) begin
                    if (ht_cnt == HTW'(TAIL_WORDS)) begin
                        prbs_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        prbs_out <= gen_beat;
                        lfsr     <= gen_state;
                        ht_cnt   <= ht_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Detector: hist keeps the previous PAT_BEATS-1 accepted beats; together
    // with the beat being accepted it forms the full comparison window.
    logic [HW-1:0]    hist;
    logic [FLW-1:0]   fill;
    logic             locked;
    logic [SLW-1:0]   phase;
    logic [PAT_W-1:0] win_next;
    logic             check_pt;
    logic             is_match;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        win_next = {hist, prbs_out};
        check_pt = (fill >= FLW'(PAT_BEATS - 1)) &&
                   (!locked || phase == SLW'(PAT_BEATS - 1));
        is_match = (win_next == pat_reg);
        cnt_inc  = (match_count == '1) ? match_count : match_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            hist          <= '0;
            fill          <= '0;
            locked        <= 1'b0;
            phase         <= '0;
            match_count   <= '0;
            pattern_found <= 1'b0;
        end else if (xfer) begin
            hist <= win_next[HW-1:0];
            if (fill != FLW'(PAT_BEATS))
                fill <= fill + 1'b1;
            if (check_pt) begin
                phase <= '0;
                if (is_match) begin
                    match_count <= cnt_inc;
                    locked      <= 1'b1;
                    if (n_reg != '0 && cnt_inc >= n_reg)
                        pattern_found <= 1'b1;
                end else begin
                    match_count <= '0;
                    locked      <= 1'b0;
                end
            end else if (locked) begin
                phase <= phase + 1'b1;
            end
        end
    end

endmodule
